// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
// Holds the FSM state encoding, table entry layout and gap-load helper.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT,
        GAP,
        FINISH
    } seq_state_t;

    localparam int ENTRY_W  = 16;
    localparam int REG_MSB  = 15;
    localparam int REG_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1A;

    localparam int GAP_W = 16;
    typedef logic [GAP_W-1:0] gap_t;

    // A gap of zero still costs one idle clock.
    function automatic gap_t gap_load(input int cycles);
        if (cycles < 1) begin
            return gap_t'(1);
        end
        return gap_t'(cycles);
    endfunction

endpackage

// File: rtl/i2c_config_sequencer_if.sv
// Command/response link between the sequencer and the I2C byte engine.
// master: sequencer side; slave: byte engine side.
interface i2c_config_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_nack;

    modport master (
        output cmd_valid,
        output cmd_dev,
        output cmd_reg,
        output cmd_data,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_nack
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dev,
        input  cmd_reg,
        input  cmd_data,
        output cmd_ready,
        output rsp_valid,
        output rsp_nack
    );

endinterface

// File: rtl/seq_gap_timer.sv
// Loadable down-counter timing the idle gap between transactions.
// Ports: clock, reset, load, load_value in; expired out (count == 1).
module seq_gap_timer
    import i2c_seq_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  gap_t load_value,
    output logic expired
);

    gap_t count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - gap_t'(1);
        end
    end

    // Loaded with N, the last of N gap clocks sees count == 1.
    assign expired = (count == gap_t'(1));

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks a {reg,data} table and issues one I2C write per entry.
// Ports: clock, reset, start, tbl_addr/tbl_data, bus (master), busy,
// done, error, fail_count. Macro I2C_SEQ_RETRY_EN adds NACK retry.
module i2c_config_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int         NUM_ENTRIES = 10,
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         MAX_RETRY   = 3,
    parameter int         GAP_CYCLES  = 500
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic [7:0]           tbl_addr,
    input  logic [ENTRY_W-1:0]   tbl_data,
    i2c_config_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [7:0]           fail_count
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_ENTRIES - 1);
    localparam gap_t       GAP_LOAD = gap_load(GAP_CYCLES);

    seq_state_t state, state_d;
    logic [7:0] idx, idx_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] data_q, data_d;
    logic       reissue, reissue_d;
    logic       done_d, error_d;
    logic [7:0] fail_d;
    logic       gap_start;
    logic       gap_expired;
`ifdef I2C_SEQ_RETRY_EN
    logic [7:0] retry, retry_d;
`endif

    seq_gap_timer u_gap (
        .clock      (clock),
        .reset      (reset),
        .load       (gap_start),
        .load_value (GAP_LOAD),
        .expired    (gap_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            reg_q      <= '0;
            data_q     <= '0;
            reissue    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            fail_count <= '0;
`ifdef I2C_SEQ_RETRY_EN
            retry      <= '0;
`endif
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            reissue    <= reissue_d;
            done       <= done_d;
            error      <= error_d;
            fail_count <= fail_d;
`ifdef I2C_SEQ_RETRY_EN
            retry      <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        reg_d     = reg_q;
        data_d    = data_q;
        reissue_d = reissue;
        done_d    = done;
        error_d   = error;
        fail_d    = fail_count;
        gap_start = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
        retry_d   = retry;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    fail_d  = '0;
`ifdef I2C_SEQ_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                reg_d   = tbl_data[REG_MSB:REG_LSB];
                data_d  = tbl_data[DATA_MSB:DATA_LSB];
                state_d = ISSUE;
            end
            ISSUE: begin
                if (bus.cmd_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.rsp_valid) begin
                    state_d   = GAP;
                    gap_start = 1'b1;
                    reissue_d = 1'b0;
                    if (bus.rsp_nack) begin
`ifdef I2C_SEQ_RETRY_EN
                        if (retry < 8'(MAX_RETRY)) begin
                            retry_d   = retry + 8'd1;
                            reissue_d = 1'b1;
                        end else begin
                            error_d = 1'b1;
                            if (fail_count != 8'hFF) begin
                                fail_d = fail_count + 8'd1;
                            end
                        end
`else
                        error_d = 1'b1;
                        if (fail_count != 8'hFF) begin
                            fail_d = fail_count + 8'd1;
                        end
`endif
                    end
                end
            end
            GAP: begin
                if (gap_expired) begin
                    if (reissue) begin
                        state_d = ISSUE;
                    end else if (idx == LAST_IDX) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        idx_d   = idx + 8'd1;
`ifdef I2C_SEQ_RETRY_EN
                        retry_d = '0;
`endif
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign tbl_addr      = idx;
    assign busy          = (state != IDLE);
    assign bus.cmd_valid = (state == ISSUE);
    assign bus.cmd_dev   = DEV_ADDR;
    assign bus.cmd_reg   = reg_q;
    assign bus.cmd_data  = data_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer: table, engine model, checks.
// Expectations follow I2C_SEQ_RETRY_EN when it is defined.
module tb_i2c_config_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start0 = 1'b0;
    logic [7:0]  tbl_addr, tbl_addr0;
    logic [15:0] tbl_data = '0;
    logic [15:0] tbl_data0 = '0;
    logic        busy, done, error;
    logic        busy0, done0, error0;
    logic [7:0]  fail_count, fail_count0;

    int tests = 0;
    int fails = 0;

    i2c_config_sequencer_if bus ();
    i2c_config_sequencer_if bus0 ();

    i2c_config_sequencer #(
        .NUM_ENTRIES (3),
        .DEV_ADDR    (7'h1A),
        .MAX_RETRY   (3),
        .GAP_CYCLES  (3)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .fail_count (fail_count)
    );

    i2c_config_sequencer #(
        .NUM_ENTRIES (3),
        .DEV_ADDR    (7'h1A),
        .MAX_RETRY   (3),
        .GAP_CYCLES  (0)
    ) u_dut0 (
        .clock      (clock),
        .reset      (reset),
        .start      (start0),
        .tbl_addr   (tbl_addr0),
        .tbl_data   (tbl_data0),
        .bus        (bus0),
        .busy       (busy0),
        .done       (done0),
        .error      (error0),
        .fail_count (fail_count0)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] rom(input logic [7:0] a);
        case (a)
            8'd0:    return 16'h10A1;
            8'd1:    return 16'h21B2;
            8'd2:    return 16'h32C3;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clock) begin
        tbl_data  <= rom(tbl_addr);
        tbl_data0 <= rom(tbl_addr0);
    end

    // Engine model: responds two clocks after acceptance.
    logic [7:0] log_reg[$];
    logic [7:0] log_data[$];
    int  issues[3];
    int  resp_cnt = 0;
    bit  pend_nack = 1'b0;
    int  nack_mode = 0;
    bit  stray_req = 1'b0;
    int  log0_n = 0;
    int  resp_cnt0 = 0;

    initial begin
        bus.rsp_valid  = 1'b0;
        bus.rsp_nack   = 1'b0;
        bus0.rsp_valid = 1'b0;
        bus0.rsp_nack  = 1'b0;
    end

    always @(negedge clock) begin
        int e;
        bus.rsp_valid = 1'b0;
        bus.rsp_nack  = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_nack  = pend_nack;
            end
        end
        if (stray_req) begin
            bus.rsp_valid = 1'b1;
            stray_req = 1'b0;
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
            log_reg.push_back(bus.cmd_reg);
            log_data.push_back(bus.cmd_data);
            e = int'(bus.cmd_reg[5:4]) - 1;
            if (e >= 0 && e < 3) begin
                issues[e]++;
            end
            pend_nack = (nack_mode == 1 && e == 1 && issues[1] <= 2) ||
                        (nack_mode == 2 && e == 0);
            resp_cnt = 2;
        end
    end

    always @(negedge clock) begin
        bus0.rsp_valid = 1'b0;
        if (resp_cnt0 > 0) begin
            resp_cnt0--;
            if (resp_cnt0 == 0) begin
                bus0.rsp_valid = 1'b1;
            end
        end
        if (bus0.cmd_valid && bus0.cmd_ready) begin
            log0_n++;
            resp_cnt0 = 2;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        log_reg.delete();
        log_data.delete();
        for (int i = 0; i < 3; i++) begin
            issues[i] = 0;
        end
    endtask

    // Pulses start, counts edges from the start edge until done.
    task automatic run_seq(input int mid, output int n, output logic d0);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        n  = 0;
        d0 = 1'bx;
        while (n < 400) begin
            @(negedge clock);
            start = (mid != 0 && n == mid);
            if (n == 0) begin
                d0 = done;
            end
            if (done) begin
                break;
            end
            @(posedge clock);
            n++;
        end
        start = 1'b0;
    endtask

    initial begin
        int   n;
        logic d0;
        bus.cmd_ready  = 1'b1;
        bus0.cmd_ready = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_fail", fail_count, 0);
        check("rst_valid", bus.cmd_valid, 0);
        check("rst_addr", tbl_addr, 0);
        check("rst_reg", bus.cmd_reg, 0);
        check("rst_data", bus.cmd_data, 0);
        check("rst_dev", bus.cmd_dev, 7'h1A);
        reset = 1'b0;

        // First command: FETCH, LOAD, then ISSUE after the second edge.
        clear_log();
        nack_mode = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("lat_fetch_addr", tbl_addr, 0);
        check("lat_fetch_valid", bus.cmd_valid, 0);
        check("lat_busy", busy, 1);
        @(negedge clock);
        check("lat_load_valid", bus.cmd_valid, 0);
        @(negedge clock);
        check("lat_issue_valid", bus.cmd_valid, 1);
        check("lat_issue_reg", bus.cmd_reg, 8'h10);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("a_done", done, 1);

        // All ACK: 8 clocks per entry with a 3-clock gap.
        clear_log();
        run_seq(0, n, d0);
        check("a_cycles", n, 24);
        check("a_done_clr", d0, 0);
        check("a_count", log_reg.size(), 3);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] w;
            w = rom(8'(i));
            if (i < log_reg.size()) begin
                check($sformatf("a_reg%0d", i), log_reg[i], w[15:8]);
                check($sformatf("a_data%0d", i), log_data[i], w[7:0]);
            end
        end
        check("a_error", error, 0);
        check("a_fail", fail_count, 0);
        @(negedge clock);
        check("a_idle", busy, 0);
        check("a_done_hold", done, 1);

        // Entry 1 NACKs twice.
        clear_log();
        nack_mode = 1;
        run_seq(0, n, d0);
`ifdef I2C_SEQ_RETRY_EN
        check("b_issues1", issues[1], 3);
        check("b_cycles", n, 36);
        check("b_error", error, 0);
        check("b_fail", fail_count, 0);
`else
        check("b_issues1", issues[1], 1);
        check("b_cycles", n, 24);
        check("b_error", error, 1);
        check("b_fail", fail_count, 1);
`endif
        check("b_issues2", issues[2], 1);
        check("b_done", done, 1);

        // Entry 0 always NACKs.
        clear_log();
        nack_mode = 2;
        run_seq(0, n, d0);
`ifdef I2C_SEQ_RETRY_EN
        check("c_issues0", issues[0], 4);
        check("c_cycles", n, 42);
`else
        check("c_issues0", issues[0], 1);
        check("c_cycles", n, 24);
`endif
        check("c_issues12", issues[1] + issues[2], 2);
        check("c_error", error, 1);
        check("c_fail", fail_count, 1);
        check("c_last_reg", log_reg[log_reg.size()-1], 8'h32);

        // Stall 20 clocks with cmd_ready low.
        clear_log();
        nack_mode = 0;
        bus.cmd_ready = 1'b0;
        fork
            run_seq(0, n, d0);
            begin
                int          k;
                logic [7:0]  r, d;
                bit          stable;
                k = 0;
                stable = 1'b1;
                while (!bus.cmd_valid && k < 50) begin
                    @(negedge clock);
                    k++;
                end
                r = bus.cmd_reg;
                d = bus.cmd_data;
                repeat (20) begin
                    @(posedge clock);
                    @(negedge clock);
                    if (!(bus.cmd_valid && bus.cmd_reg == r &&
                          bus.cmd_data == d)) begin
                        stable = 1'b0;
                    end
                end
                check("d_hold", stable, 1);
                check("d_reg", r, 8'h10);
                check("d_data", d, 8'hA1);
                check("d_no_accept", log_reg.size(), 0);
                bus.cmd_ready = 1'b1;
            end
        join
        check("d_cycles", n, 44);
        check("d_count", log_reg.size(), 3);
        check("d_error_clr", error, 0);
        check("d_fail_clr", fail_count, 0);

        // Start pulsed mid-sequence is ignored.
        clear_log();
        run_seq(10, n, d0);
        check("e_cycles", n, 24);
        check("e_count", log_reg.size(), 3);

        // Reset while in WAIT.
        clear_log();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!bus.cmd_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check("f_in_wait", bus.cmd_valid, 0);
        reset = 1'b1;
        resp_cnt = 0;
        @(negedge clock);
        check("f_busy", busy, 0);
        check("f_valid", bus.cmd_valid, 0);
        reset = 1'b0;
        stray_req = 1'b1;
        repeat (6) @(negedge clock);
        check("f_stray_busy", busy, 0);
        check("f_stray_count", log_reg.size(), 1);
        check("f_stray_done", done, 0);

        // Zero gap: one idle clock, 6 clocks per entry.
        @(negedge clock);
        start0 = 1'b1;
        @(posedge clock);
        n = 0;
        while (n < 200) begin
            @(negedge clock);
            start0 = 1'b0;
            if (done0) begin
                break;
            end
            @(posedge clock);
            n++;
        end
        check("g_cycles", n, 18);
        check("g_count", log0_n, 3);
        check("g_error", error0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_config_sequencer.md
I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 10: number of {register, data} table entries, legal range 1..256.
REQ-002 SHALL have parameter DEV_ADDR, default 7'h1A: 7-bit target device address.
REQ-003 SHALL have parameter MAX_RETRY, default 3: re-issues per entry after NACK.
REQ-004 SHALL have parameter GAP_CYCLES, default 500: idle clocks between transactions.
REQ-005 SHALL use reset reset, synchronous, active-high; clock clock.
REQ-006 SHALL provide these ports (name, direction, width, meaning), clock and reset first:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  pulse; begins sequence
- tbl_addr  out  8  table read index
- tbl_data  in  16  {reg[15:8], data[7:0]}; valid one clock after tbl_addr
- cmd_valid  out  1  transaction request to byte engine
- cmd_ready  in  1  engine accepts request
- cmd_dev  out  7  device address (= DEV_ADDR)
- cmd_reg  out  8  register address
- cmd_data  out  8  write data
- rsp_valid  in  1  one-clock pulse; transaction complete
- rsp_nack  in  1  NACK flag, qualified by rsp_valid
- busy  out  1  high in every state except IDLE
- done  out  1  level; sequence finished, cleared by next start
- error  out  1  sticky; any entry abandoned, cleared by next start
- fail_count  out  8  entries abandoned, saturates at 255

Function
REQ-007 SHALL implement states IDLE, FETCH, LOAD, ISSUE, WAIT, GAP, FINISH.
REQ-008 IDLE: start=1 -> FETCH; idx=0, retry=0, done/error/fail_count cleared; start is ignored in all other states.
REQ-009 FETCH: tbl_addr=idx for one clock -> LOAD.
REQ-010 LOAD: capture tbl_data into cmd_reg/cmd_data -> ISSUE; first cmd_valid rises exactly 3 clocks after start is sampled.
REQ-011 ISSUE: cmd_valid=1 with cmd_reg/cmd_data stable until the clock cmd_ready=1 is sampled -> WAIT; cmd_valid=0 the following clock.
REQ-012 WAIT: rsp_valid & !rsp_nack -> GAP, marked advance; rsp_valid is ignored outside WAIT.
REQ-013 WAIT: rsp_valid & rsp_nack with retry<MAX_RETRY -> retry+1, GAP, marked reissue (same entry, no refetch).
REQ-014 WAIT: rsp_valid & rsp_nack with retry==MAX_RETRY -> error=1, fail_count+1 (saturating), GAP, marked advance.
REQ-015 GAP: hold exactly max(GAP_CYCLES,1) clocks, then: reissue -> ISSUE; advance with idx==NUM_ENTRIES-1 -> FINISH; otherwise advance -> FETCH with idx+1, retry=0.
REQ-016 FINISH: done=1 -> IDLE next clock; done holds until next start.
REQ-017 idx SHALL be 8 bits and never wrap; NUM_ENTRIES=256 terminates at idx 255.

Reset
REQ-018 reset SHALL force IDLE, cmd_valid=0, tbl_addr=0, cmd_reg=0, cmd_data=0, busy=0, done=0, error=0, fail_count=0, retry=0, gap counter=0; cmd_dev is constant DEV_ADDR.
REQ-019 reset mid-sequence SHALL abort the current transaction within one clock without issuing further commands; the byte engine shares the same reset.

Configuration
REQ-020 With I2C_SEQ_RETRY_EN defined, NACK retry per REQ-013/014 SHALL be compiled in.
REQ-021 Without I2C_SEQ_RETRY_EN, MAX_RETRY SHALL be ignored, the retry counter SHALL be absent, and any NACK SHALL abandon the entry per REQ-014.

Structure
REQ-022 Shared package i2c_seq_pkg SHALL hold the state encoding, table entry width (16), the {reg,data} field positions and the default codec address constant.
REQ-023 Gap timing SHALL live in one sub-module seq_gap_timer (loadable down-counter, expired flag).

Verification
REQ-024 NUM_ENTRIES=3, all ACK, cmd_ready always 1 -> three commands in table order, done=1, error=0, fail_count=0.
REQ-025 Entry 1 NACKs twice then ACKs, MAX_RETRY=3 -> entry 1 issued 3 times with no refetch, error=0.
REQ-026 Entry 0 always NACKs, MAX_RETRY=3 -> 4 issues of entry 0, error=1, fail_count=1; entries 1..2 still sent; without I2C_SEQ_RETRY_EN -> 1 issue.
REQ-027 cmd_ready held low 20 clocks -> cmd_valid and payload stable for all 20 clocks; single acceptance.
REQ-028 reset asserted in WAIT -> next clock IDLE, busy=0, cmd_valid=0; later stray rsp_valid ignored.
REQ-029 start pulsed while busy, and GAP_CYCLES=0 -> start ignored; gap is exactly 1 clock.
